// File: rtl/isi_ms_dem.sv
// rtl/isi_ms_dem.sv - segmented DEM encoder with 2nd-order MS and 1st-order ISI shaping per array
// Optional ISI_MS_OVR_FLAG_EN adds a sticky out-of-range input flag (ovr).

module isi_ms_dem_grp #(
    parameter int N  = 18,
    parameter int VW = 6,
    parameter int SW = 8,
    parameter int IW = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [VW-1:0]   i_v,
    input  logic            i_isi_byp,
    input  logic            i_mis_byp,
    output logic [N-1:0]    o_sv,
    output logic [N-1:0]    o_st,
    output logic [N*SW-1:0] o_score
);
    localparam int CW = $clog2(N + 1);
    localparam int AW = IW + 2;
    localparam logic [VW-1:0]        V_MAX = VW'(N);
    localparam logic signed [AW-1:0] N_A   = AW'(N);
    localparam logic signed [AW-1:0] I_MAX = AW'((1 << (IW - 1)) - 1);
    localparam logic signed [AW-1:0] I_MIN = -I_MAX;
    localparam logic signed [AW-1:0] S_MAX = AW'((1 << (SW - 1)) - 1);
    localparam logic signed [AW-1:0] S_MIN = -S_MAX;

    logic signed [SW-1:0] r_s  [N];
    logic signed [IW-1:0] r_a1 [N];
    logic signed [IW-1:0] r_a2 [N];
    logic signed [IW-1:0] r_b  [N];
    logic [N-1:0]         r_sv;
    logic [N-1:0]         r_st;

    logic [CW-1:0]        w_v;
    logic [CW-1:0]        w_t;
    logic [CW-1:0]        w_rank [N];
    logic [N-1:0]         w_sel;
    logic [N-1:0]         w_tr;
    logic signed [AW-1:0] w_va;
    logic signed [AW-1:0] w_ta;
    logic signed [IW-1:0] w_a1n [N];
    logic signed [IW-1:0] w_a2n [N];
    logic signed [IW-1:0] w_bn  [N];
    logic signed [SW-1:0] w_sn  [N];

    // Symmetric saturation keeps the loops free of a DC bias at the rails.
    function automatic logic signed [IW-1:0] f_sat_iw(input logic signed [AW-1:0] x);
        logic signed [IW-1:0] y;
        y = x[IW-1:0];
        if (x > I_MAX)
            y = I_MAX[IW-1:0];
        else if (x < I_MIN)
            y = I_MIN[IW-1:0];
        return y;
    endfunction

    function automatic logic signed [SW-1:0] f_sat_sw(input logic signed [AW-1:0] x);
        logic signed [SW-1:0] y;
        y = x[SW-1:0];
        if (x > S_MAX)
            y = S_MAX[SW-1:0];
        else if (x < S_MIN)
            y = S_MIN[SW-1:0];
        return y;
    endfunction

    always_comb begin
        w_v = CW'(i_v);
        if (i_v[VW-1])
            w_v = '0;
        else if (i_v > V_MAX)
            w_v = CW'(N);
    end

    // Rank is a strict permutation (ties broken by index), so exactly V elements are selected.
    always_comb begin
        w_t = '0;
        for (int k = 0; k < N; k++) begin
            w_rank[k] = '0;
            for (int j = 0; j < N; j++) begin
                if ((r_s[j] < r_s[k]) || ((r_s[j] == r_s[k]) && (j < k)))
                    w_rank[k] = w_rank[k] + CW'(1);
            end
            w_sel[k] = (w_rank[k] < w_v);
            w_tr[k]  = w_sel[k] ^ r_sv[k];
            w_t      = w_t + CW'(w_tr[k]);
        end
    end

    always_comb begin
        w_va = AW'(w_v);
        w_ta = AW'(w_t);
        for (int k = 0; k < N; k++) begin
            w_a1n[k] = '0;
            w_a2n[k] = '0;
            w_bn[k]  = '0;
            if (!i_mis_byp) begin
                w_a1n[k] = f_sat_iw(AW'(r_a1[k]) + (w_sel[k] ? N_A : '0) - w_va);
                w_a2n[k] = f_sat_iw(AW'(r_a2[k]) + AW'(w_a1n[k]));
            end
            if (!i_isi_byp)
                w_bn[k] = f_sat_iw(AW'(r_b[k]) + (w_tr[k] ? N_A : '0) - w_ta);
            w_sn[k] = f_sat_sw(AW'(w_a2n[k]) + AW'(w_bn[k]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sv <= '0;
            r_st <= '0;
            for (int k = 0; k < N; k++) begin
                r_a1[k] <= '0;
                r_a2[k] <= '0;
                r_b[k]  <= '0;
                r_s[k]  <= '0;
            end
        end else begin
            r_sv <= w_sel;
            r_st <= w_tr;
            for (int k = 0; k < N; k++) begin
                r_a1[k] <= w_a1n[k];
                r_a2[k] <= w_a2n[k];
                r_b[k]  <= w_bn[k];
                r_s[k]  <= w_sn[k];
            end
        end
    end

    assign o_sv = r_sv;
    assign o_st = r_st;

    for (genvar k = 0; k < N; k++) begin : g_pack
        assign o_score[k*SW +: SW] = r_s[k];
    end
endmodule

module isi_ms_dem #(
    parameter int NB = 18,
    parameter int NC = 6,
    parameter int SW = 8,
    parameter int IW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [5:0]    VB,
    input  logic [3:0]    VC,
    input  logic          ISI_SEL,
    input  logic          MIS_SEL,
    output logic [NB-1:0] SVBout,
    output logic [NB-1:0] STBout,
    output logic [NC-1:0] SVCout,
    output logic [NC-1:0] STCout,
    output logic [SW-1:0] TBS0,
    output logic [SW-1:0] TBS1,
    output logic [SW-1:0] TBS2,
    output logic [SW-1:0] TBS3,
    output logic [SW-1:0] TBS4,
    output logic [SW-1:0] TBS5,
    output logic [SW-1:0] TBS6,
    output logic [SW-1:0] TBS7,
    output logic [SW-1:0] TBS8,
    output logic [SW-1:0] TBS9,
    output logic [SW-1:0] TBS10,
    output logic [SW-1:0] TBS11,
    output logic [SW-1:0] TBS12,
    output logic [SW-1:0] TBS13,
    output logic [SW-1:0] TBS14,
    output logic [SW-1:0] TBS15,
    output logic [SW-1:0] TBS16,
    output logic [SW-1:0] TBS17,
    output logic [SW-1:0] TCS0,
    output logic [SW-1:0] TCS1,
    output logic [SW-1:0] TCS2,
    output logic [SW-1:0] TCS3,
    output logic [SW-1:0] TCS4,
    output logic [SW-1:0] TCS5
`ifdef ISI_MS_OVR_FLAG_EN
    ,
    output logic          ovr
`endif
);
    logic [NB*SW-1:0] w_bscore;
    logic [NC*SW-1:0] w_cscore;

    isi_ms_dem_grp #(.N(NB), .VW(6), .SW(SW), .IW(IW)) u_grp_b (
        .clk       (clk),
        .rst       (rst),
        .i_v       (VB),
        .i_isi_byp (ISI_SEL),
        .i_mis_byp (MIS_SEL),
        .o_sv      (SVBout),
        .o_st      (STBout),
        .o_score   (w_bscore)
    );

    isi_ms_dem_grp #(.N(NC), .VW(4), .SW(SW), .IW(IW)) u_grp_c (
        .clk       (clk),
        .rst       (rst),
        .i_v       (VC),
        .i_isi_byp (ISI_SEL),
        .i_mis_byp (MIS_SEL),
        .o_sv      (SVCout),
        .o_st      (STCout),
        .o_score   (w_cscore)
    );

    assign TBS0  = w_bscore[0*SW  +: SW];
    assign TBS1  = w_bscore[1*SW  +: SW];
    assign TBS2  = w_bscore[2*SW  +: SW];
    assign TBS3  = w_bscore[3*SW  +: SW];
    assign TBS4  = w_bscore[4*SW  +: SW];
    assign TBS5  = w_bscore[5*SW  +: SW];
    assign TBS6  = w_bscore[6*SW  +: SW];
    assign TBS7  = w_bscore[7*SW  +: SW];
    assign TBS8  = w_bscore[8*SW  +: SW];
    assign TBS9  = w_bscore[9*SW  +: SW];
    assign TBS10 = w_bscore[10*SW +: SW];
    assign TBS11 = w_bscore[11*SW +: SW];
    assign TBS12 = w_bscore[12*SW +: SW];
    assign TBS13 = w_bscore[13*SW +: SW];
    assign TBS14 = w_bscore[14*SW +: SW];
    assign TBS15 = w_bscore[15*SW +: SW];
    assign TBS16 = w_bscore[16*SW +: SW];
    assign TBS17 = w_bscore[17*SW +: SW];
    assign TCS0  = w_cscore[0*SW  +: SW];
    assign TCS1  = w_cscore[1*SW  +: SW];
    assign TCS2  = w_cscore[2*SW  +: SW];
    assign TCS3  = w_cscore[3*SW  +: SW];
    assign TCS4  = w_cscore[4*SW  +: SW];
    assign TCS5  = w_cscore[5*SW  +: SW];

`ifdef ISI_MS_OVR_FLAG_EN
    logic r_ovr;

    always_ff @(posedge clk) begin
        if (rst)
            r_ovr <= 1'b0;
        else if (VB[5] || (VB > 6'(NB)) || VC[3] || (VC > 4'(NC)))
            r_ovr <= 1'b1;
    end

    assign ovr = r_ovr;
`endif
endmodule

// File: tb/tb_isi_ms_dem.sv
// tb/tb_isi_ms_dem.sv - directed self-checking bench for isi_ms_dem

module tb_isi_ms_dem;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  vb;
    logic [3:0]  vc;
    logic        isi_sel;
    logic        mis_sel;
    logic [17:0] svb, stb;
    logic [5:0]  svc, stc;
    logic signed [7:0] tbs [18];
    logic signed [7:0] tcs [6];
`ifdef ISI_MS_OVR_FLAG_EN
    logic        ovr;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    isi_ms_dem dut (
        .clk(clk), .rst(rst), .VB(vb), .VC(vc), .ISI_SEL(isi_sel), .MIS_SEL(mis_sel),
        .SVBout(svb), .STBout(stb), .SVCout(svc), .STCout(stc),
        .TBS0(tbs[0]), .TBS1(tbs[1]), .TBS2(tbs[2]), .TBS3(tbs[3]), .TBS4(tbs[4]),
        .TBS5(tbs[5]), .TBS6(tbs[6]), .TBS7(tbs[7]), .TBS8(tbs[8]), .TBS9(tbs[9]),
        .TBS10(tbs[10]), .TBS11(tbs[11]), .TBS12(tbs[12]), .TBS13(tbs[13]),
        .TBS14(tbs[14]), .TBS15(tbs[15]), .TBS16(tbs[16]), .TBS17(tbs[17]),
        .TCS0(tcs[0]), .TCS1(tcs[1]), .TCS2(tcs[2]), .TCS3(tcs[3]), .TCS4(tcs[4]),
        .TCS5(tcs[5])
`ifdef ISI_MS_OVR_FLAG_EN
        , .ovr(ovr)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int score_nz();
        int n;
        n = 0;
        for (int k = 0; k < 18; k++) if (tbs[k] != 0) n++;
        for (int k = 0; k < 6; k++)  if (tcs[k] != 0) n++;
        return n;
    endfunction

    function automatic int score_out_of_range();
        int n;
        n = 0;
        for (int k = 0; k < 18; k++) if (tbs[k] > 127 || tbs[k] < -127) n++;
        for (int k = 0; k < 6; k++)  if (tcs[k] > 127 || tcs[k] < -127) n++;
        return n;
    endfunction

    task automatic test_reset();
        rst = 1'b1; vb = 6'd13; vc = 4'd5; isi_sel = 1'b0; mis_sel = 1'b0;
        repeat (3) tick();
        n_vec++; if (svb !== 18'h0) begin n_err++; $display("FAIL reset_svb: got %h want 0", svb); end
        n_vec++; if (stb !== 18'h0) begin n_err++; $display("FAIL reset_stb: got %h want 0", stb); end
        n_vec++; if (svc !== 6'h0) begin n_err++; $display("FAIL reset_svc: got %h want 0", svc); end
        n_vec++; if (stc !== 6'h0) begin n_err++; $display("FAIL reset_stc: got %h want 0", stc); end
        n_vec++; if (score_nz() != 0) begin n_err++; $display("FAIL reset_scores: %0d nonzero, want 0", score_nz()); end
`ifdef ISI_MS_OVR_FLAG_EN
        n_vec++; if (ovr !== 1'b0) begin n_err++; $display("FAIL reset_ovr: got %b want 0", ovr); end
`endif
    endtask

    task automatic test_bypass();
        rst = 1'b1; isi_sel = 1'b1; mis_sel = 1'b1; vb = 6'd5; vc = 4'd2;
        tick();
        rst = 1'b0;
        tick();
        n_vec++; if (svb !== 18'h0001F) begin n_err++; $display("FAIL byp_svb: got %h want 0001f", svb); end
        n_vec++; if (svc !== 6'h03) begin n_err++; $display("FAIL byp_svc: got %h want 03", svc); end
        n_vec++; if (stb !== 18'h0001F) begin n_err++; $display("FAIL byp_stb_first: got %h want 0001f", stb); end
        n_vec++; if (stc !== 6'h03) begin n_err++; $display("FAIL byp_stc_first: got %h want 03", stc); end
        n_vec++; if (score_nz() != 0) begin n_err++; $display("FAIL byp_scores: %0d nonzero, want 0", score_nz()); end
        tick();
        n_vec++; if (svb !== 18'h0001F) begin n_err++; $display("FAIL byp_svb2: got %h want 0001f", svb); end
        n_vec++; if (stb !== 18'h0) begin n_err++; $display("FAIL byp_stb_second: got %h want 0", stb); end
        n_vec++; if (stc !== 6'h0) begin n_err++; $display("FAIL byp_stc_second: got %h want 0", stc); end
    endtask

    task automatic test_ms_rotation();
        logic [17:0] one_b;
        logic [5:0]  one_c;
        rst = 1'b1; isi_sel = 1'b1; mis_sel = 1'b0; vb = 6'd1; vc = 4'd1;
        tick();
        rst = 1'b0;
        one_b = 18'h1;
        one_c = 6'h1;
        for (int t = 0; t < 36; t++) begin
            tick();
            n_vec++;
            if ($countones(svb) != 1) begin n_err++; $display("FAIL rot_popcnt t=%0d: got %h want one bit", t, svb); end
            if (t <= 16) begin
                n_vec++;
                if (svb !== (one_b << t)) begin n_err++; $display("FAIL rot_b t=%0d: got %h want %h", t, svb, one_b << t); end
            end
            if (t < 6) begin
                n_vec++;
                if (svc !== (one_c << t)) begin n_err++; $display("FAIL rot_c t=%0d: got %h want %h", t, svc, one_c << t); end
            end
        end
    endtask

    task automatic test_both_loops();
        logic [17:0] prev_b;
        logic [5:0]  prev_c;
        rst = 1'b1; isi_sel = 1'b0; mis_sel = 1'b0; vb = 6'd9; vc = 4'd3;
        tick();
        rst = 1'b0;
        prev_b = '0;
        prev_c = '0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 0) begin
                n_vec++; if (svb !== 18'h001FF) begin n_err++; $display("FAIL both_first_b: got %h want 001ff", svb); end
                n_vec++; if (svc !== 6'h07) begin n_err++; $display("FAIL both_first_c: got %h want 07", svc); end
            end
            n_vec++; if ($countones(svb) != 9) begin n_err++; $display("FAIL both_pop_b i=%0d: got %0d want 9", i, $countones(svb)); end
            n_vec++; if ($countones(svc) != 3) begin n_err++; $display("FAIL both_pop_c i=%0d: got %0d want 3", i, $countones(svc)); end
            n_vec++; if (stb !== (svb ^ prev_b)) begin n_err++; $display("FAIL both_stb i=%0d: got %h want %h", i, stb, svb ^ prev_b); end
            n_vec++; if (stc !== (svc ^ prev_c)) begin n_err++; $display("FAIL both_stc i=%0d: got %h want %h", i, stc, svc ^ prev_c); end
            prev_b = svb;
            prev_c = svc;
        end
    endtask

    task automatic test_clamp();
        rst = 1'b1; isi_sel = 1'b1; mis_sel = 1'b1; vb = 6'd18; vc = 4'd6;
        tick();
        rst = 1'b0;
        tick();
        n_vec++; if (svb !== 18'h3FFFF) begin n_err++; $display("FAIL clamp_edge_b: got %h want 3ffff", svb); end
        n_vec++; if (svc !== 6'h3F) begin n_err++; $display("FAIL clamp_edge_c: got %h want 3f", svc); end
`ifdef ISI_MS_OVR_FLAG_EN
        n_vec++; if (ovr !== 1'b0) begin n_err++; $display("FAIL clamp_edge_ovr: got %b want 0", ovr); end
`endif
        vb = 6'd25; vc = 4'b1101;
        tick();
        n_vec++; if (svb !== 18'h3FFFF) begin n_err++; $display("FAIL clamp_hi_b: got %h want 3ffff", svb); end
        n_vec++; if (svc !== 6'h00) begin n_err++; $display("FAIL clamp_neg_c: got %h want 00", svc); end
`ifdef ISI_MS_OVR_FLAG_EN
        n_vec++; if (ovr !== 1'b1) begin n_err++; $display("FAIL clamp_ovr_set: got %b want 1", ovr); end
`endif
        vb = 6'b111111; vc = 4'd7;
        tick();
        n_vec++; if (svb !== 18'h0) begin n_err++; $display("FAIL clamp_neg_b: got %h want 0", svb); end
        n_vec++; if (svc !== 6'h3F) begin n_err++; $display("FAIL clamp_hi_c: got %h want 3f", svc); end
        vb = 6'd4; vc = 4'd1;
        tick();
`ifdef ISI_MS_OVR_FLAG_EN
        n_vec++; if (ovr !== 1'b1) begin n_err++; $display("FAIL clamp_ovr_sticky: got %b want 1", ovr); end
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
`ifdef ISI_MS_OVR_FLAG_EN
        n_vec++; if (ovr !== 1'b0) begin n_err++; $display("FAIL clamp_ovr_clear: got %b want 0", ovr); end
`endif
    endtask

    task automatic test_sat_reset();
        rst = 1'b1; isi_sel = 1'b0; mis_sel = 1'b0; vb = 6'd9; vc = 4'd3;
        tick();
        rst = 1'b0;
        tick();
        n_vec++; if (tbs[0] !== 8'sd18) begin n_err++; $display("FAIL sat_tbs0: got %0d want 18", tbs[0]); end
        n_vec++; if (tbs[17] !== -8'sd18) begin n_err++; $display("FAIL sat_tbs17: got %0d want -18", tbs[17]); end
        n_vec++; if (tcs[0] !== 8'sd6) begin n_err++; $display("FAIL sat_tcs0: got %0d want 6", tcs[0]); end
        n_vec++; if (tcs[5] !== -8'sd6) begin n_err++; $display("FAIL sat_tcs5: got %0d want -6", tcs[5]); end
        for (int i = 0; i < 20; i++) begin
            vb = (i % 2 == 1) ? 6'd18 : 6'd0;
            vc = (i % 2 == 1) ? 4'd6 : 4'd0;
            tick();
            n_vec++;
            if (score_out_of_range() != 0) begin n_err++; $display("FAIL sat_range i=%0d: %0d scores beyond +-127, want 0", i, score_out_of_range()); end
        end
        rst = 1'b1;
        tick();
        n_vec++; if (score_nz() != 0) begin n_err++; $display("FAIL sat_rst_scores: %0d nonzero, want 0", score_nz()); end
        n_vec++; if (svb !== 18'h0) begin n_err++; $display("FAIL sat_rst_svb: got %h want 0", svb); end
        rst = 1'b0; vb = 6'd3; vc = 4'd2;
        tick();
        n_vec++; if (svb !== 18'h00007) begin n_err++; $display("FAIL sat_post_svb: got %h want 00007", svb); end
        n_vec++; if (svc !== 6'h03) begin n_err++; $display("FAIL sat_post_svc: got %h want 03", svc); end
        n_vec++; if (stb !== 18'h00007) begin n_err++; $display("FAIL sat_post_stb: got %h want 00007", stb); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_bypass();
        test_ms_rotation();
        test_both_loops();
        test_clamp();
        test_sat_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
